// File: rtl/serial_key_reader.sv
// serial_key_reader
//   Host-side initiator for the serial key/ID device (decoded at BA13=0,
//   BA12=1). On an accepted start it issues four unlock accesses carrying
//   the nibbles of unlock_seq ([15:12] first), then L read accesses
//   (L = read_len, 0 meaning 16). Each read samples sdrd on its last strobe
//   cycle; the bits are assembled MSB-first into a right-justified word.
//   Every access is SETUP (1 clk), STROBE (STROBE_CYCLES clks, sser low),
//   RECOVER (RECOVER_CYCLES clks, sser high).
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : request pulse, honoured only while idle
//   unlock_seq    : four unlock command nibbles, latched on accepted start
//   read_len      : number of read bits (1..16, 0 = 16), latched on start
//   busy          : transfer in progress
//   done          : one-cycle pulse as the block returns to idle
//   data          : received word, updated together with done
//   sser          : device strobe, active low
//   ba13, ba12    : device address select lines
//   ba_cmd        : command nibble on BA7..BA4
//   br_w          : read/write qualifier
//   sdrd          : serial data from the device

module serial_key_reader #(
  parameter int unsigned STROBE_CYCLES  = 2,
  parameter int unsigned RECOVER_CYCLES = 1,
  parameter logic [3:0]  READ_CMD       = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] unlock_seq,
  input  logic [4:0]  read_len,
  output logic        busy,
  output logic        done,
  output logic [15:0] data,
  output logic        sser,
  output logic        ba13,
  output logic        ba12,
  output logic [3:0]  ba_cmd,
  output logic        br_w,
  input  logic        sdrd
);

  localparam int unsigned TMAX = (STROBE_CYCLES > RECOVER_CYCLES) ? STROBE_CYCLES : RECOVER_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_STROBE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t         r_state;
  logic [15:0]    r_unlock;
  logic [4:0]     r_len;
  logic [4:0]     r_acc;
  logic [4:0]     r_bits;
  logic [TW-1:0]  r_tcnt;
  logic [15:0]    r_shreg;
  logic [15:0]    r_data;
  logic           r_done;

  logic           w_strobe_last;
  logic           w_recover_last;
  logic           w_is_read;
  logic           w_last_access;
  logic [3:0]     w_unlock_nib;

  assign w_strobe_last  = (r_tcnt == TW'(STROBE_CYCLES - 1));
  assign w_recover_last = (r_tcnt == TW'(RECOVER_CYCLES - 1));
  assign w_is_read      = (r_acc >= 5'd4);
  // The bit counter has already counted the final read by its RECOVER phase.
  assign w_last_access  = w_is_read && (r_bits == r_len);

  always_comb begin
    w_unlock_nib = r_unlock[15:12];
    case (r_acc[1:0])
      2'd0: w_unlock_nib = r_unlock[15:12];
      2'd1: w_unlock_nib = r_unlock[11:8];
      2'd2: w_unlock_nib = r_unlock[7:4];
      2'd3: w_unlock_nib = r_unlock[3:0];
      default: w_unlock_nib = r_unlock[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_unlock <= '0;
      r_len    <= '0;
      r_acc    <= '0;
      r_bits   <= '0;
      r_tcnt   <= '0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_unlock <= unlock_seq;
            r_len    <= (read_len == 5'd0) ? 5'd16 : read_len;
            r_acc    <= '0;
            r_bits   <= '0;
            r_tcnt   <= '0;
            r_shreg  <= '0;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_tcnt  <= '0;
          r_state <= S_STROBE;
        end
        S_STROBE: begin
          if (w_strobe_last) begin
            r_tcnt  <= '0;
            r_state <= S_RECOVER;
            if (w_is_read) begin
              r_shreg <= {r_shreg[14:0], sdrd};
              r_bits  <= r_bits + 5'd1;
            end
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_RECOVER: begin
          if (w_recover_last) begin
            r_tcnt <= '0;
            if (w_last_access) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              r_data  <= r_shreg;
            end else begin
              r_acc   <= r_acc + 5'd1;
              r_state <= S_SETUP;
            end
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus lines decode from registered state; r_acc only advances on the
  // RECOVER->SETUP edge, so the command never moves while sser is low.
  always_comb begin
    busy   = (r_state != S_IDLE);
    done   = r_done;
    data   = r_data;
    sser   = (r_state != S_STROBE);
    ba13   = (r_state == S_IDLE);
    ba12   = (r_state != S_IDLE);
    br_w   = (r_state != S_IDLE);
    ba_cmd = '0;
    if (r_state != S_IDLE)
      ba_cmd = w_is_read ? READ_CMD : w_unlock_nib;
  end

endmodule

// File: doc/serial_key_reader.md
Name: serial_key_reader

Overview:
Host-side initiator for the serial key/ID device decoded at BA13=0, BA12=1. It issues a fixed four-nibble unlock sequence, then a programmable number of read accesses. Each read samples the device's SDRD bit, and the bits are assembled MSB-first into a 16-bit word. The block sits between the host CPU register interface and the device bus pins (SSER, BA13, BA12, BA7..BA4, BR_W, SDRD).

Parameters:
STROBE_CYCLES, 2, clocks SSER is held low per access (min 1)
RECOVER_CYCLES, 1, clocks SSER is held high after each access before the next setup (min 1)
READ_CMD, 4'h0, nibble driven on BA7..BA4 during read accesses

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
unlock_seq  in  16  four command nibbles, issued [15:12] first; sampled on accepted start
read_len  in  5  number of read bits, 1..16; 0 is treated as 16; sampled on accepted start
busy  out  1  high from the cycle after an accepted start through the last RECOVER cycle
done  out  1  one-cycle pulse after the final access
data  out  16  assembled word, right-justified; updated only with done
sser  out  1  device strobe, active low
ba13  out  1  address bit 13
ba12  out  1  address bit 12
ba_cmd  out  4  command nibble on BA7..BA4
br_w  out  1  read/write qualifier
sdrd  in  1  serial data from device; sampled on the last STROBE cycle of a read access

Behaviour:
- Reset values, and values in IDLE: sser=1, ba13=1, ba12=0, ba_cmd=0, br_w=0, busy=0, done=0, data=16'h0000. The device is deselected in this state.
- States: IDLE, SETUP, STROBE, RECOVER.
- Access counter: 5 bits. Bit counter: 5 bits. Strobe/recover counter sized for max(STROBE_CYCLES, RECOVER_CYCLES).
- IDLE: when start=1 at an edge, latch unlock_seq and the effective length L (read_len, or 16 if 0). Clear the shift register and go to SETUP; busy=1 from the next cycle. start=0 keeps IDLE.
- SETUP (1 clk):
  - ba13=0, ba12=1, br_w=1, sser=1.
  - ba_cmd = current unlock nibble for accesses 0..3, READ_CMD for accesses 4..3+L.
  - Next state: STROBE.
- STROBE (STROBE_CYCLES clks):
  - Address and ba_cmd are held and sser=0.
  - On the last STROBE cycle of a read access: shreg <= {shreg[14:0], sdrd}.
  - Unlock accesses ignore sdrd.
- RECOVER (RECOVER_CYCLES clks):
  - sser=1; address and ba_cmd are held.
  - Afterwards, if accesses remain, go to SETUP with the next access. Otherwise go to IDLE, pulse done=1 and load data <= shreg, with busy=0 in that same cycle.
- Access length = 1+STROBE_CYCLES+RECOVER_CYCLES clks (4 with defaults). Total busy cycles = (4+L)*(access length).
- Address/command lines change only on entry to SETUP or on return to IDLE, never while sser=0.
- For L<16, data holds only the L received bits in [L-1:0], upper bits 0. The first-received bit is the MSB of that field.
- start while busy is ignored and is not queued. start asserted in the done cycle is accepted: the FSM is already in IDLE, so the next SETUP follows immediately.
- rst asserted mid-access: at the next edge all outputs return to reset values, including sser=1 even during STROBE. Any partial word is discarded and done is not pulsed.
- unlock_seq and read_len changes while busy have no effect.

Test Plan:
- Reset, default params, start with unlock_seq=16'hA53C and read_len=8. Required:
  - ba_cmd goes A,5,3,C then 0 (×8).
  - Each access is 1 clk setup, 2 clks sser=0, 1 clk recover; busy high for exactly 48 clks.
  - done pulses once; drive sdrd as 1,0,1,1,0,0,1,0 and expect data=16'h00B2.
- read_len=0 with sdrd held at 1 -> 20 accesses, busy=80 clks, data=16'hFFFF.
- read_len=1 with sdrd=1 -> 5 accesses, data=16'h0001; a second start in the done cycle begins SETUP on the next clock.
- Bus checks:
  - Pulse start at busy cycle 10 -> ignored; access count unchanged; exactly one done.
  - sdrd toggles on non-sampling cycles -> data reflects only the last-STROBE samples.
- rst during the 3rd read's STROBE -> next cycle sser=1, ba13=1, ba12=0, br_w=0, busy=0; no done; data stays 0.
- STROBE_CYCLES=1, RECOVER_CYCLES=3 with read_len=2 -> access length 5, busy=30 clks; sser is never low on two consecutive accesses without ≥3 high cycles between them.
